// File: rtl/mac_array_pipelined.sv
// ---------------------------------------------------------------------------
// mac_array_pipelined
//
// Multi-lane, two-stage pipelined signed multiply-accumulate engine. Each of
// the LANES lanes forms a dot product of signed activations and signed
// weights, accumulates with saturation, and on the last beat of a dot product
// rounds (half-up), shifts and saturates the sum into an OUT_WIDTH result.
// A single global advance signal moves both pipeline stages together, so the
// whole engine stalls as a unit when the output register is full.
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : synchronous active-high reset, highest priority
//   clear      : synchronous flush of the partial accumulation and stage 1
//   in_valid   : input beat valid
//   in_ready   : input beat accepted when in_valid && in_ready (combinational)
//   in_last    : beat closes the current dot product
//   data_in    : LANES packed signed activations, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   weight_in  : LANES packed signed weights, lane i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   out_valid  : result held in the output register
//   out_ready  : downstream accepts the result
//   out_data   : LANES packed quantised results
//   out_ovf    : per-lane sticky accumulator saturation flag for this result
//   out_count  : beats in this result, saturating at all-ones
//
// Parameter constraints: ACC_WIDTH >= DATA_WIDTH + WEIGHT_WIDTH,
// 2 <= OUT_WIDTH <= ACC_WIDTH, 0 <= SHIFT <= ACC_WIDTH-1.
// ---------------------------------------------------------------------------
module mac_array_pipelined #(
   parameter int DATA_WIDTH   = 16,
   parameter int WEIGHT_WIDTH = 8,
   parameter int ACC_WIDTH    = 24,
   parameter int OUT_WIDTH    = 16,
   parameter int SHIFT        = 4,
   parameter int LANES        = 4,
   parameter int COUNT_WIDTH  = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clear,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          in_last,
   input  logic [LANES*DATA_WIDTH-1:0]   data_in,
   input  logic [LANES*WEIGHT_WIDTH-1:0] weight_in,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [LANES*OUT_WIDTH-1:0]    out_data,
   output logic [LANES-1:0]              out_ovf,
   output logic [COUNT_WIDTH-1:0]        out_count
);

   localparam int PROD_WIDTH = DATA_WIDTH + WEIGHT_WIDTH;
   localparam int WIDE_WIDTH = ACC_WIDTH + 1;

   localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
   localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

   // Half an LSB of the shifted result; (1 << SHIFT) >> 1 yields zero when
   // SHIFT is zero, so no rounding is applied in that build.
   localparam logic signed [WIDE_WIDTH-1:0] ROUND_BIAS = WIDE_WIDTH'((1 << SHIFT) >> 1);

   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

   // Stage 1 registers
   logic                         pValid;
   logic                         pLast;
   logic signed [PROD_WIDTH-1:0] pProd [LANES];

   // Stage 2 accumulation state
   logic signed [ACC_WIDTH-1:0]  acc [LANES];
   logic [LANES-1:0]             ovf;
   logic [COUNT_WIDTH-1:0]       cnt;

   // Combinational working values
   logic                         adv;
   logic                         stage2Fire;
   logic                         resultFire;
   logic signed [PROD_WIDTH-1:0] dataExt   [LANES];
   logic signed [PROD_WIDTH-1:0] weightExt [LANES];
   logic signed [PROD_WIDTH-1:0] prodNext  [LANES];
   logic signed [WIDE_WIDTH-1:0] sumWide   [LANES];
   logic signed [ACC_WIDTH-1:0]  sumClamp  [LANES];
   logic signed [WIDE_WIDTH-1:0] roundSum  [LANES];
   logic signed [WIDE_WIDTH-1:0] qWide     [LANES];
   logic signed [OUT_WIDTH-1:0]  qOut      [LANES];
   logic [LANES-1:0]             laneHit;
   logic [COUNT_WIDTH-1:0]       cntInc;

   // The whole engine advances together: it moves only when the output
   // register can take a new result and no flush is in progress. The same
   // condition is exposed as in_ready so an accepted beat always has a slot.
   assign adv        = (!out_valid || out_ready) && !clear;
   assign in_ready   = adv;
   assign stage2Fire = adv && pValid;
   assign resultFire = stage2Fire && pLast;

   // Per-lane products for stage 1. Both operands are sign-extended to the
   // full product width first so the multiply is exact and lint-clean.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         dataExt[i]   = PROD_WIDTH'($signed(data_in[i*DATA_WIDTH +: DATA_WIDTH]));
         weightExt[i] = PROD_WIDTH'($signed(weight_in[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
         prodNext[i]  = dataExt[i] * weightExt[i];
      end
   end

   // Stage 2 arithmetic. The sum is formed one bit wider than the accumulator
   // so overflow is visible, then clamped back into accumulator range. The
   // quantiser works on the clamped value, again one bit wider so adding the
   // rounding bias to a near-maximum sum cannot wrap, then saturates the
   // shifted value into the output width.
   always_comb begin
      laneHit = '0;
      for (int i = 0; i < LANES; i++) begin
         sumWide[i] = WIDE_WIDTH'(acc[i]) + WIDE_WIDTH'(pProd[i]);
         sumClamp[i] = '0;
         if (sumWide[i] > WIDE_WIDTH'(ACC_MAX)) begin
            sumClamp[i] = ACC_MAX;
            laneHit[i]  = 1'b1;
         end else if (sumWide[i] < WIDE_WIDTH'(ACC_MIN)) begin
            sumClamp[i] = ACC_MIN;
            laneHit[i]  = 1'b1;
         end else begin
            sumClamp[i] = sumWide[i][ACC_WIDTH-1:0];
         end

         roundSum[i] = WIDE_WIDTH'(sumClamp[i]) + ROUND_BIAS;
         qWide[i]    = roundSum[i] >>> SHIFT;
         qOut[i]     = '0;
         if (qWide[i] > WIDE_WIDTH'(OUT_MAX)) begin
            qOut[i] = OUT_MAX;
         end else if (qWide[i] < WIDE_WIDTH'(OUT_MIN)) begin
            qOut[i] = OUT_MIN;
         end else begin
            qOut[i] = qWide[i][OUT_WIDTH-1:0];
         end
      end
   end

   // Beat counter increment, held at all-ones once it saturates.
   always_comb begin
      cntInc = cnt;
      if (cnt != COUNT_MAX) begin
         cntInc = cnt + COUNT_WIDTH'(1);
      end
   end

   // Stage 1 register: captures the beat and its products whenever the
   // engine advances. A flush kills the in-flight beat so it never reaches
   // the accumulator; the product values themselves are don't-care then.
   always_ff @(posedge clk) begin
      if (rst) begin
         pValid <= 1'b0;
         pLast  <= 1'b0;
         pProd  <= '{default: '0};
      end else if (clear) begin
         pValid <= 1'b0;
      end else if (adv) begin
         pValid <= in_valid;
         pLast  <= in_last;
         pProd  <= prodNext;
      end
   end

   // Stage 2 accumulation: fold the stage-1 product into each lane. On the
   // last beat the state restarts from zero in the same edge, which is what
   // lets single-beat dot products run back to back at full rate.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         acc <= '{default: '0};
         ovf <= '0;
         cnt <= '0;
      end else if (stage2Fire) begin
         if (pLast) begin
            acc <= '{default: '0};
            ovf <= '0;
            cnt <= '0;
         end else begin
            acc <= sumClamp;
            ovf <= ovf | laneHit;
            cnt <= cntInc;
         end
      end
   end

   // Output register. A new result may replace one being accepted in the
   // same edge; otherwise an accepted result simply empties the register.
   // The payload only changes when a new result loads, so it is stable for
   // as long as the result waits for out_ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ovf   <= '0;
         out_count <= '0;
      end else if (resultFire) begin
         out_valid <= 1'b1;
         for (int i = 0; i < LANES; i++) begin
            out_data[i*OUT_WIDTH +: OUT_WIDTH] <= qOut[i];
         end
         out_ovf   <= ovf | laneHit;
         out_count <= cntInc;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mac_array_pipelined.sv
// ---------------------------------------------------------------------------
// tb_mac_array_pipelined
//
// Self-checking bench for mac_array_pipelined. Two instances share one
// stimulus stream: dutA uses the default SHIFT=4 build, dutB a SHIFT=0 build.
// A behavioural model folds every accepted beat into plain integer sums and
// queues a finished result per dot product; a compare process checks both
// instances against that queue whenever they present a result. Directed
// sequences add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_mac_array_pipelined;

   localparam int LANES = 4;
   localparam int DW    = 16;
   localparam int WW    = 8;
   localparam int OW    = 16;
   localparam int CW    = 8;

   localparam longint ACC_HI = 64'sd8388607;
   localparam longint ACC_LO = -64'sd8388608;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst;
   logic                 clear;
   logic                 in_valid;
   logic                 in_last;
   logic [LANES*DW-1:0]  data_in;
   logic [LANES*WW-1:0]  weight_in;
   logic                 out_ready;

   logic                 inReadyA, outValidA;
   logic [LANES*OW-1:0]  outDataA;
   logic [LANES-1:0]     outOvfA;
   logic [CW-1:0]        outCountA;

   logic                 inReadyB, outValidB;
   logic [LANES*OW-1:0]  outDataB;
   logic [LANES-1:0]     outOvfB;
   logic [CW-1:0]        outCountB;

   int  compared   = 0;
   int  mismatched = 0;
   bit  started    = 1'b0;

   mac_array_pipelined #(
      .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .ACC_WIDTH(24), .OUT_WIDTH(OW),
      .SHIFT(4), .LANES(LANES), .COUNT_WIDTH(CW)
   ) dutA (
      .clk(clk), .rst(rst), .clear(clear),
      .in_valid(in_valid), .in_ready(inReadyA), .in_last(in_last),
      .data_in(data_in), .weight_in(weight_in),
      .out_valid(outValidA), .out_ready(out_ready),
      .out_data(outDataA), .out_ovf(outOvfA), .out_count(outCountA)
   );

   mac_array_pipelined #(
      .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .ACC_WIDTH(24), .OUT_WIDTH(OW),
      .SHIFT(0), .LANES(LANES), .COUNT_WIDTH(CW)
   ) dutB (
      .clk(clk), .rst(rst), .clear(clear),
      .in_valid(in_valid), .in_ready(inReadyB), .in_last(in_last),
      .data_in(data_in), .weight_in(weight_in),
      .out_valid(outValidB), .out_ready(out_ready),
      .out_data(outDataB), .out_ovf(outOvfB), .out_count(outCountB)
   );

   // One queued result: clamped accumulator per lane, sticky flags, count.
   typedef struct packed {
      logic [LANES-1:0][31:0] acc;
      logic [LANES-1:0]       ovf;
      logic [CW-1:0]          cnt;
   } resT;

   resT    expQ[$];
   longint mAcc [LANES];
   logic [LANES-1:0] mOvf;
   int     mCnt;

   // Every comparison goes through here so the counters stay in one place.
   task automatic checkOutput(input string name, input longint actual, input longint expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic longint laneOf(input logic [LANES*OW-1:0] v, input int i);
      return longint'($signed(v[i*OW +: OW]));
   endfunction

   // Round half up, arithmetic shift, saturate to a 16-bit signed result.
   function automatic longint quant(input longint a, input int sh);
      longint r;
      r = (a + ((longint'(1) << sh) >>> 1)) >>> sh;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      return r;
   endfunction

   function automatic logic [LANES*DW-1:0] lane0Data(input int d);
      logic [LANES*DW-1:0] r;
      r = '0;
      r[DW-1:0] = DW'(d);
      return r;
   endfunction

   function automatic logic [LANES*WW-1:0] lane0Weight(input int w);
      logic [LANES*WW-1:0] r;
      r = '0;
      r[WW-1:0] = WW'(w);
      return r;
   endfunction

   function automatic logic [LANES*DW-1:0] allData(input int d);
      return {LANES{DW'(d)}};
   endfunction

   function automatic logic [LANES*WW-1:0] allWeight(input int w);
      return {LANES{WW'(w)}};
   endfunction

   // Presents one beat and holds it until the engine takes it. Acceptance
   // is judged at the rising edge, before any register there updates.
   task automatic applyStimulus(input logic [LANES*DW-1:0] d, input logic [LANES*WW-1:0] w,
                                input logic last);
      bit taken;
      int t;
      in_valid  = 1'b1;
      data_in   = d;
      weight_in = w;
      in_last   = last;
      taken     = 1'b0;
      t         = 0;
      while (!taken && t < 200) begin
         @(posedge clk);
         taken = inReadyA;
         t++;
      end
      if (!taken) checkOutput("beat acceptance timeout", 0, 1);
      @(negedge clk);
   endtask

   // Behavioural model: each accepted beat is folded straight into integer
   // running sums; a last beat closes the dot product and queues its result.
   // Results leave the queue when the downstream handshake takes them.
   always @(posedge clk) begin
      if (rst) begin
         expQ.delete();
         for (int i = 0; i < LANES; i++) mAcc[i] = 0;
         mOvf = '0;
         mCnt = 0;
      end else begin
         if (outValidA && out_ready && expQ.size() > 0) void'(expQ.pop_front());
         if (clear) begin
            for (int i = 0; i < LANES; i++) mAcc[i] = 0;
            mOvf = '0;
            mCnt = 0;
         end else if (in_valid && inReadyA) begin
            for (int i = 0; i < LANES; i++) begin
               longint s;
               s = mAcc[i] + longint'($signed(data_in[i*DW +: DW])) *
                             longint'($signed(weight_in[i*WW +: WW]));
               if (s > ACC_HI) begin s = ACC_HI; mOvf[i] = 1'b1; end
               if (s < ACC_LO) begin s = ACC_LO; mOvf[i] = 1'b1; end
               mAcc[i] = s;
            end
            mCnt = (mCnt < 255) ? mCnt + 1 : 255;
            if (in_last) begin
               resT e;
               for (int i = 0; i < LANES; i++) e.acc[i] = 32'(mAcc[i]);
               e.ovf = mOvf;
               e.cnt = CW'(mCnt);
               expQ.push_back(e);
               for (int i = 0; i < LANES; i++) mAcc[i] = 0;
               mOvf = '0;
               mCnt = 0;
            end
         end
      end
   end

   // Compare process, sampled mid-cycle once inputs have settled.
   always @(negedge clk) begin
      #2;
      if (started && !rst) begin
         checkOutput("in_ready A", longint'(inReadyA), longint'((!outValidA || out_ready) && !clear));
         checkOutput("in_ready B", longint'(inReadyB), longint'((!outValidB || out_ready) && !clear));
         if (outValidA || outValidB) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected result present", 1, 0);
            end else begin
               resT e;
               e = expQ[0];
               checkOutput("out_valid A", longint'(outValidA), 1);
               checkOutput("out_valid B", longint'(outValidB), 1);
               for (int i = 0; i < LANES; i++) begin
                  checkOutput($sformatf("A lane%0d data", i), laneOf(outDataA, i),
                              quant(longint'($signed(e.acc[i])), 4));
                  checkOutput($sformatf("B lane%0d data", i), laneOf(outDataB, i),
                              quant(longint'($signed(e.acc[i])), 0));
               end
               checkOutput("A ovf", longint'(outOvfA), longint'(e.ovf));
               checkOutput("B ovf", longint'(outOvfB), longint'(e.ovf));
               checkOutput("A count", longint'(outCountA), longint'(e.cnt));
               checkOutput("B count", longint'(outCountB), longint'(e.cnt));
            end
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      data_in = '0; weight_in = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      $display("[TB] reset state");
      checkOutput("reset out_valid", longint'(outValidA), 0);
      checkOutput("reset out_data", longint'(outDataA), 0);
      checkOutput("reset out_ovf", longint'(outOvfA), 0);
      checkOutput("reset out_count", longint'(outCountA), 0);
      checkOutput("reset in_ready", longint'(inReadyA), 1);
      started = 1'b1;

      // Small dot product: 4 x (3*2) = 24 -> (24+8)>>4 = 2; then -24 -> -1.
      $display("[TB] basic dot products");
      for (int b = 1; b <= 4; b++) applyStimulus(lane0Data(3), lane0Weight(2), b == 4);
      in_valid = 1'b0;
      checkOutput("latency: not yet valid", longint'(outValidA), 0);
      @(negedge clk);
      checkOutput("latency: valid", longint'(outValidA), 1);
      checkOutput("basic A lane0", laneOf(outDataA, 0), 2);
      checkOutput("basic B lane0", laneOf(outDataB, 0), 24);
      checkOutput("basic count", longint'(outCountA), 4);
      checkOutput("basic ovf", longint'(outOvfA), 0);
      @(negedge clk);
      checkOutput("basic result consumed", longint'(outValidA), 0);
      for (int b = 1; b <= 4; b++) applyStimulus(lane0Data(-3), lane0Weight(2), b == 4);
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("negative A lane0", laneOf(outDataA, 0), -1);
      checkOutput("negative B lane0", laneOf(outDataB, 0), -24);
      repeat (2) @(negedge clk);

      // Saturation: 3 x 4161409 clamps to 8388607 -> 32767; negative to -32768.
      $display("[TB] saturation");
      for (int b = 1; b <= 3; b++) applyStimulus(allData(32767), allWeight(127), b == 3);
      in_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < LANES; i++) begin
         checkOutput($sformatf("pos sat A lane%0d", i), laneOf(outDataA, i), 32767);
         checkOutput($sformatf("pos sat B lane%0d", i), laneOf(outDataB, i), 32767);
      end
      checkOutput("pos sat ovf", longint'(outOvfA), 15);
      checkOutput("pos sat count", longint'(outCountA), 3);
      repeat (2) @(negedge clk);
      for (int b = 1; b <= 3; b++) applyStimulus(allData(-32768), allWeight(127), b == 3);
      in_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < LANES; i++) begin
         checkOutput($sformatf("neg sat A lane%0d", i), laneOf(outDataA, i), -32768);
      end
      checkOutput("neg sat ovf", longint'(outOvfA), 15);
      repeat (2) @(negedge clk);

      // Backpressure: result (40+8)>>4 = 3 held for 5 cycles; the beat offered
      // meanwhile (100 -> 6) goes in once out_ready returns.
      $display("[TB] backpressure");
      out_ready = 1'b0;
      applyStimulus(lane0Data(40), lane0Weight(1), 1'b1);
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("stall result valid", longint'(outValidA), 1);
      fork
         applyStimulus(lane0Data(100), lane0Weight(1), 1'b1);
         begin
            for (int s = 0; s < 5; s++) begin
               checkOutput("stall in_ready", longint'(inReadyA), 0);
               checkOutput("stall lane0", laneOf(outDataA, 0), 3);
               checkOutput("stall count", longint'(outCountA), 1);
               checkOutput("stall ovf", longint'(outOvfA), 0);
               @(negedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("after stall lane0", laneOf(outDataA, 0), 6);
      checkOutput("after stall count", longint'(outCountA), 1);
      @(negedge clk);
      checkOutput("stalled beat taken once", longint'(outValidA), 0);
      repeat (2) @(negedge clk);

      // Back-to-back single-beat products k*1 on the SHIFT=0 build.
      $display("[TB] back-to-back");
      fork
         begin
            for (int k = 1; k <= 8; k++) applyStimulus(lane0Data(k), lane0Weight(1), 1'b1);
            in_valid = 1'b0;
         end
         begin
            int t;
            t = 0;
            while (!outValidB && t < 20) begin
               @(negedge clk);
               t++;
            end
            if (!outValidB) checkOutput("b2b first result timeout", 0, 1);
            for (int k = 1; k <= 8; k++) begin
               checkOutput("b2b valid", longint'(outValidB), 1);
               checkOutput("b2b B lane0", laneOf(outDataB, 0), k);
               checkOutput("b2b A lane0", laneOf(outDataA, 0), (k == 8) ? 1 : 0);
               checkOutput("b2b count", longint'(outCountB), 1);
               @(negedge clk);
            end
            checkOutput("b2b drained", longint'(outValidB), 0);
         end
      join
      repeat (2) @(negedge clk);

      // clear after 2 of 4 beats, then 3 x 16 = 48 -> (48+8)>>4 = 3.
      $display("[TB] clear");
      for (int b = 1; b <= 2; b++) applyStimulus(lane0Data(16), lane0Weight(1), 1'b0);
      clear     = 1'b1;
      in_valid  = 1'b1;
      data_in   = lane0Data(1000);
      weight_in = lane0Weight(1);
      in_last   = 1'b0;
      #1;
      checkOutput("clear in_ready", longint'(inReadyA), 0);
      @(negedge clk);
      clear    = 1'b0;
      in_valid = 1'b0;
      for (int b = 1; b <= 3; b++) applyStimulus(lane0Data(16), lane0Weight(1), b == 3);
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("clear A lane0", laneOf(outDataA, 0), 3);
      checkOutput("clear B lane0", laneOf(outDataB, 0), 48);
      checkOutput("clear count", longint'(outCountA), 3);
      repeat (2) @(negedge clk);

      // Reset with a pending result and a partial sum in flight.
      $display("[TB] reset mid-operation");
      out_ready = 1'b0;
      applyStimulus(lane0Data(40), lane0Weight(1), 1'b1);
      applyStimulus(lane0Data(500), lane0Weight(1), 1'b0);
      in_valid = 1'b0;
      #1;
      checkOutput("pending before reset", longint'(outValidA), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("reset drops result", longint'(outValidA), 0);
      checkOutput("reset in_ready", longint'(inReadyA), 1);
      out_ready = 1'b1;
      for (int b = 1; b <= 4; b++) applyStimulus(lane0Data(3), lane0Weight(2), b == 4);
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("post reset A lane0", laneOf(outDataA, 0), 2);
      checkOutput("post reset B lane0", laneOf(outDataB, 0), 24);
      checkOutput("post reset count", longint'(outCountA), 4);
      repeat (2) @(negedge clk);

      // Counter saturation: 300 beats of 1*1 -> count 255, (300+8)>>4 = 19.
      $display("[TB] count saturation");
      for (int b = 1; b <= 300; b++) applyStimulus(lane0Data(1), lane0Weight(1), b == 300);
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("sat count", longint'(outCountA), 255);
      checkOutput("sat count A lane0", laneOf(outDataA, 0), 19);
      checkOutput("sat count B lane0", laneOf(outDataB, 0), 300);

      repeat (3) @(negedge clk);
      checkOutput("all results delivered", longint'(expQ.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mac_array_pipelined.md
# mac_array_pipelined

Multi-lane, two-stage pipelined signed multiply-accumulate engine: LANES independent dot-product lanes with saturating accumulation, round-and-saturate output quantisation, per-lane overflow reporting and a valid/ready handshake on both sides. It is the parametrised successor to the single-lane MAC. It sits at the edge of a systolic column, where it consumes packed activation/weight beats and emits quantised dot products.

## Interface
- DATA_WIDTH, 16: signed activation width per lane
- WEIGHT_WIDTH, 8: signed weight width per lane
- ACC_WIDTH, 24: signed accumulator width; must be ≥ DATA_WIDTH+WEIGHT_WIDTH
- OUT_WIDTH, 16: signed output width per lane; must be ≤ ACC_WIDTH
- SHIFT, 4: arithmetic right shift applied at quantisation, range 0..ACC_WIDTH-1
- LANES, 4: number of parallel lanes
- COUNT_WIDTH, 8: width of the beat counter
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- clear  in  1  synchronous flush of partial accumulation
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_last  in  1  beat is the final beat of the current dot product
- data_in  in  LANES*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- weight_in  in  LANES*WEIGHT_WIDTH  lane i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
- out_valid  out  1  result held in output register
- out_ready  in  1  downstream accepts result
- out_data  out  LANES*OUT_WIDTH  quantised result, same lane packing
- out_ovf  out  LANES  per-lane sticky accumulator saturation flag for this result
- out_count  out  COUNT_WIDTH  number of beats in this result, saturating at 2^COUNT_WIDTH-1

## Operation
- Global advance: adv = in_ready = (!out_valid || out_ready) && !clear. When adv=0, both stages hold every register.
- Stage 1, on adv: p_valid←in_valid, p_last←in_last, and per-lane p_prod←signed data × signed weight, full DATA_WIDTH+WEIGHT_WIDTH bits.
- Stage 2, on adv && p_valid:
  - sum = acc + sign-extended p_prod, computed in ACC_WIDTH+1 bits.
  - Clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; if clamping occurs, set that lane's ovf sticky bit.
  - cnt←cnt+1, saturating at its maximum.
- Last beat, when p_last is also set:
  - Per lane, quantise the clamped sum: q = (sum + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, computed without intermediate overflow. This is round-half-up.
  - Saturate q to OUT_WIDTH.
  - Load out_data with q, out_ovf with ovf including this beat's clamp, out_count with cnt+1 (saturating), and set out_valid←1.
  - In the same edge, set acc←0, ovf←0, cnt←0.
- Output handshake:
  - out_valid && out_ready with no new result this edge: out_valid←0.
  - A new result and an acceptance in the same edge: the new result replaces the old one and out_valid stays 1.
  - While out_valid && !out_ready: out_data, out_ovf and out_count are stable.
- clear: acc←0, ovf←0, cnt←0, p_valid←0. in_ready is 0 during clear, so no beat is accepted in that cycle. The output register and out_valid are unaffected.
- rst: clears all state; it has priority over clear and over the handshake.

## Timing
- Reset values:
  - in_ready=1 in the cycle after reset; it is combinational, so it also depends on clear.
  - out_valid=0, out_data=0, out_ovf=0, out_count=0.
  - Internally acc, ovf, cnt and p_valid are 0.
- Latency: a last beat accepted at edge N produces out_valid=1 after edge N+1, unless the pipeline stalls.
- Throughput: one beat per cycle while out_ready=1, including back-to-back single-beat dot products, which give one result per cycle.
- in_ready is combinational from out_valid, out_ready and clear. No other combinational input→output path exists.
- in_valid=0 cycles insert bubbles and do not affect accumulation.
- Reset mid-operation discards in-flight products, partial sums and any pending result.

## Test plan
- Lane 0: data 3, weight 2, 4 beats with last on beat 4; other lanes 0. Expect out_data lane0=2 ((24+8)>>4), out_count=4, out_ovf=0, out_valid 2 cycles after the last beat. With data −3 the result is −1.
- Positive saturation: all lanes data 32767, weight 127, 3 beats. Expect acc clamped to 8388607, out_ovf=4'hF, out_data=32767 per lane. Negative case: data −32768, weight 127 gives −32768.
- Backpressure: result pending with out_ready=0 for 5 cycles. Expect in_ready=0 and out_data, out_count and out_ovf stable for all 5 cycles. The beat presented during the stall is accepted exactly once after out_ready=1.
- Back-to-back: 8 single-beat dot products with data k and weight 1 (k=1..8), SHIFT=0 build, out_ready=1. Expect 8 consecutive out_valid cycles with values 1..8 and out_count=1.
- clear after 2 of 4 beats, then a fresh 3-beat dot product of data 16, weight 1. Expect out_data=3 ((48+8)>>4) and out_count=3. The beat offered during clear is not accepted.
- Assert rst with a partial sum and a pending result. Expect out_valid=0 next cycle, and the subsequent dot product to be unaffected by pre-reset state.
